// File: rtl/byte_change_uart_tx.sv
// Queues every change of a monitored byte and sends each queued byte as a UART 8N1 frame, LSB first.
// Latency: enqueue on the edge that sees the change, pop one edge later, start bit begins after the pop.
// Backpressure: none upstream; changes that arrive while the queue is full are dropped and overflow is set.
module byte_change_uart_tx #(
    parameter int CLKS_PER_BIT = 104,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    data_in,
    output logic                          tx,
    output logic                          busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overflow
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int CW = $clog2(CLKS_PER_BIT);
    localparam logic [CW-1:0] BAUD_LAST = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] BAUD_ONE  = CW'(1);
    localparam logic [AW:0]   PTR_ONE   = (AW+1)'(1);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] START = 2'd1;
    localparam logic [1:0] DATA  = 2'd2;
    localparam logic [1:0] STOP  = 2'd3;

    logic [7:0]    prev;
    logic          primed;
    logic [7:0]    mem [FIFO_DEPTH];
    logic [AW:0]   wr_ptr;
    logic [AW:0]   rd_ptr;
    logic [1:0]    state;
    logic [CW-1:0] baud_cnt;
    logic [2:0]    bit_idx;
    logic [7:0]    shift;

    logic fifo_empty;
    logic fifo_full;
    logic change;
    logic deq;
    logic enq;

    assign fifo_level = wr_ptr - rd_ptr;
    assign fifo_empty = (wr_ptr == rd_ptr);
    assign fifo_full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign change     = primed && (data_in != prev);
    assign deq        = (state == IDLE) && !fifo_empty;
    // A pop on the same edge frees a slot, so a change is accepted even when full.
    assign enq        = change && (!fifo_full || deq);

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            prev     <= 8'h00;
            primed   <= 1'b0;
            overflow <= 1'b0;
            wr_ptr   <= '0;
            for (int i = 0; i < FIFO_DEPTH; i++) begin
                mem[i] <= 8'h00;
            end
        end else begin
            if (!primed) begin
                prev   <= data_in;
                primed <= 1'b1;
            end else if (data_in != prev) begin
                prev <= data_in;
            end
            if (enq) begin
                mem[wr_ptr[AW-1:0]] <= data_in;
                wr_ptr              <= wr_ptr + PTR_ONE;
            end
            if (change && !enq) begin
                overflow <= 1'b1;
            end
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state    <= IDLE;
            baud_cnt <= '0;
            bit_idx  <= 3'd0;
            shift    <= 8'h00;
            tx       <= 1'b1;
            busy     <= 1'b0;
            rd_ptr   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    if (deq) begin
                        shift    <= mem[rd_ptr[AW-1:0]];
                        rd_ptr   <= rd_ptr + PTR_ONE;
                        state    <= START;
                        baud_cnt <= '0;
                        tx       <= 1'b0;
                        busy     <= 1'b1;
                    end
                end
                START: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        bit_idx  <= 3'd0;
                        state    <= DATA;
                        tx       <= shift[0];
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                DATA: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            state <= STOP;
                            tx    <= 1'b1;
                        end else begin
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                STOP: begin
                    if (baud_cnt == BAUD_LAST) begin
                        baud_cnt <= '0;
                        state    <= IDLE;
                        busy     <= 1'b0;
                    end else begin
                        baud_cnt <= baud_cnt + BAUD_ONE;
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_byte_change_uart_tx.sv
// Bench for byte_change_uart_tx: fixed vectors, hand-built corner sequences and random changes
// checked every cycle against a time-based model of queue contents and frame timing.
module tb_byte_change_uart_tx;
    localparam int C     = 4;
    localparam int DEPTH = 4;
    localparam int C2    = 104;

    logic       clk = 1'b0;
    logic       rst_n = 1'b1;
    logic       rst_n2 = 1'b1;
    logic [7:0] data_in = 8'hA5;
    logic [7:0] data_in2 = 8'h00;
    logic       tx, busy, overflow;
    logic       tx2, busy2, overflow2;
    logic [2:0] fifo_level, fifo_level2;

    byte_change_uart_tx #(.CLKS_PER_BIT(C), .FIFO_DEPTH(DEPTH)) dut (
        .clk(clk), .rst_n(rst_n), .data_in(data_in), .tx(tx), .busy(busy),
        .fifo_level(fifo_level), .overflow(overflow)
    );

    byte_change_uart_tx #(.CLKS_PER_BIT(C2), .FIFO_DEPTH(DEPTH)) dut2 (
        .clk(clk), .rst_n(rst_n2), .data_in(data_in2), .tx(tx2), .busy(busy2),
        .fifo_level(fifo_level2), .overflow(overflow2)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int failures = 0;
    int cyc = 0;

    // Model: a queue of pending bytes plus the start time of the frame on the line.
    logic [7:0] m_q[$];
    logic [7:0] m_prev, m_byte;
    bit         m_primed, m_ovf, m_active;
    int         m_start;

    bit tx_tr[$], busy_tr[$], tx2_tr[$], busy2_tr[$];
    logic [7:0] dec_bytes[$];
    int         dec_starts[$];

    typedef struct {
        logic [7:0] din;
        int         n;
        bit         tx;
        bit         busy;
        int         lvl;
        bit         ovf;
    } vec_t;
    vec_t tbl[$];

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s at cycle %0d: got %0h, expected %0h", name, cyc, act, exp);
        end
    endtask

    task automatic model_reset();
        m_q.delete();
        m_prev = 8'h00;
        m_byte = 8'h00;
        m_primed = 1'b0;
        m_ovf = 1'b0;
        m_active = 1'b0;
        m_start = 0;
    endtask

    task automatic step();
        bit deq, eb, et;
        int d;
        cyc++;
        if (rst_n) begin
            deq = !(m_active && (cyc - 1 - m_start) < 10*C) && (m_q.size() > 0);
            if (deq) begin
                m_byte = m_q.pop_front();
                m_active = 1'b1;
                m_start = cyc;
            end
            if (!m_primed) begin
                m_primed = 1'b1;
                m_prev = data_in;
            end else if (data_in != m_prev) begin
                if (m_q.size() < DEPTH) m_q.push_back(data_in);
                else m_ovf = 1'b1;
                m_prev = data_in;
            end
        end
        @(posedge clk);
        #1;
        eb = m_active && (cyc - m_start) < 10*C;
        et = 1'b1;
        if (eb) begin
            d = (cyc - m_start) / C;
            if (d == 0) et = 1'b0;
            else if (d < 9) et = m_byte[d-1];
        end
        chk("model_tx", int'(tx), int'(et));
        chk("model_busy", int'(busy), int'(eb));
        chk("model_level", int'(fifo_level), m_q.size());
        chk("model_overflow", int'(overflow), int'(m_ovf));
        tx_tr.push_back(tx);
        busy_tr.push_back(busy);
        tx2_tr.push_back(tx2);
        busy2_tr.push_back(busy2);
    endtask

    task automatic decode(input int from);
        logic [7:0] b;
        dec_bytes.delete();
        dec_starts.delete();
        for (int i = from; i + 10*C <= busy_tr.size(); i++) begin
            if (busy_tr[i] && (i == 0 || !busy_tr[i-1])) begin
                for (int j = 0; j < 8; j++) b[j] = tx_tr[i + (j+1)*C + C/2];
                dec_bytes.push_back(b);
                dec_starts.push_back(i);
            end
        end
    endtask

    task automatic async_reset(input int hold);
        #2;
        rst_n = 1'b0;
        model_reset();
        repeat (hold) step();
        rst_n = 1'b1;
    endtask

    initial begin
        #1000000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int mark, cnt, found, r, len, lo_run, bz_run, hi_cnt;
        logic [7:0] exp3[5];
        logic [7:0] exp4[6];

        model_reset();
        #1 rst_n = 1'b0;
        rst_n2 = 1'b0;
        repeat (3) step();
        chk("rst_tx", int'(tx), 1);
        chk("rst_busy", int'(busy), 0);
        chk("rst_level", int'(fifo_level), 0);
        chk("rst_ovf", int'(overflow), 0);
        chk("rst2_tx", int'(tx2), 1);
        chk("rst2_level", int'(fifo_level2), 0);
        rst_n = 1'b1;
        rst_n2 = 1'b1;

        // Priming: a held non-zero value must not be reported as a change.
        mark = busy_tr.size();
        repeat (50) step();
        cnt = 0;
        for (int i = mark; i < busy_tr.size(); i++) if (busy_tr[i] || !tx_tr[i]) cnt++;
        chk("prime_no_frame", cnt, 0);
        chk("prime_level", int'(fifo_level), 0);

        tbl.push_back('{8'h3C, 1, 1'b1, 1'b0, 1, 1'b0});
        tbl.push_back('{8'h3C, 4, 1'b0, 1'b1, 0, 1'b0});
        tbl.push_back('{8'h3C, 8, 1'b0, 1'b1, 0, 1'b0});
        tbl.push_back('{8'h3C, 16, 1'b1, 1'b1, 0, 1'b0});
        tbl.push_back('{8'h3C, 8, 1'b0, 1'b1, 0, 1'b0});
        tbl.push_back('{8'h3C, 4, 1'b1, 1'b1, 0, 1'b0});
        tbl.push_back('{8'h3C, 3, 1'b1, 1'b0, 0, 1'b0});
        foreach (tbl[v]) begin
            for (int k = 0; k < tbl[v].n; k++) begin
                data_in = tbl[v].din;
                step();
                chk("vec_tx", int'(tx), int'(tbl[v].tx));
                chk("vec_busy", int'(busy), int'(tbl[v].busy));
                chk("vec_level", int'(fifo_level), tbl[v].lvl);
                chk("vec_ovf", int'(overflow), int'(tbl[v].ovf));
            end
        end

        // Six changes back to back: one pops, four queue, the sixth is dropped.
        exp3 = '{8'h11, 8'h22, 8'h33, 8'h44, 8'h55};
        mark = busy_tr.size();
        data_in = 8'h11; step();
        data_in = 8'h22; step();
        data_in = 8'h33; step();
        data_in = 8'h44; step();
        data_in = 8'h55; step();
        chk("burst_level_full", int'(fifo_level), 4);
        chk("burst_ovf_before", int'(overflow), 0);
        data_in = 8'h66; step();
        chk("burst_level_drop", int'(fifo_level), 4);
        chk("burst_ovf_set", int'(overflow), 1);
        repeat (230) step();
        decode(mark);
        chk("burst_frames", dec_bytes.size(), 5);
        for (int k = 0; k < 5 && k < dec_bytes.size(); k++) chk("burst_byte", int'(dec_bytes[k]), int'(exp3[k]));
        for (int k = 1; k < 5 && k < dec_starts.size(); k++) chk("burst_period", dec_starts[k] - dec_starts[k-1], 41);
        chk("burst_ovf_sticky", int'(overflow), 1);

        // Full queue with a change landing on the pop edge is accepted without overflow.
        data_in = 8'h00;
        async_reset(3);
        repeat (3) step();
        chk("full_ovf_cleared", int'(overflow), 0);
        exp4 = '{8'h81, 8'h82, 8'h83, 8'h84, 8'h85, 8'h9A};
        mark = busy_tr.size();
        for (int k = 0; k < 5; k++) begin
            data_in = exp4[k];
            step();
        end
        chk("full_level", int'(fifo_level), 4);
        found = 0;
        for (int n = 0; n < 200 && found == 0; n++) begin
            if (!busy && fifo_level == 3'd4) begin
                data_in = 8'h9A;
                step();
                chk("full_pop_level", int'(fifo_level), 4);
                chk("full_pop_ovf", int'(overflow), 0);
                found = 1;
            end else begin
                step();
            end
        end
        chk("full_pop_reached", found, 1);
        repeat (280) step();
        decode(mark);
        chk("full_frames", dec_bytes.size(), 6);
        for (int k = 0; k < 6 && k < dec_bytes.size(); k++) chk("full_byte", int'(dec_bytes[k]), int'(exp4[k]));
        chk("full_ovf_final", int'(overflow), 0);

        // Reset in the middle of a frame with two bytes still queued.
        data_in = 8'h10; step();
        data_in = 8'h20; step();
        data_in = 8'h30; step();
        repeat (15) step();
        chk("midrst_busy_before", int'(busy), 1);
        chk("midrst_level_before", int'(fifo_level), 2);
        #2;
        rst_n = 1'b0;
        model_reset();
        #1;
        chk("midrst_tx_now", int'(tx), 1);
        chk("midrst_busy_now", int'(busy), 0);
        chk("midrst_level_now", int'(fifo_level), 0);
        chk("midrst_ovf_now", int'(overflow), 0);
        repeat (3) step();
        rst_n = 1'b1;
        mark = busy_tr.size();
        repeat (120) step();
        cnt = 0;
        for (int i = mark; i < busy_tr.size(); i++) if (busy_tr[i]) cnt++;
        chk("midrst_no_stale", cnt, 0);

        for (int n = 0; n < 1500; n++) begin
            r = $urandom_range(0, 999);
            if (r < 3) begin
                async_reset(2);
            end else if (r < 10) begin
                len = $urandom_range(3, 7);
                for (int k = 0; k < len; k++) begin
                    data_in = data_in + 8'($urandom_range(1, 255));
                    step();
                end
            end else begin
                if (r < 60) data_in = 8'($urandom_range(0, 255));
                step();
            end
        end

        // Full-rate frame on the 104-clock instance.
        repeat (500) step();
        mark = tx2_tr.size();
        data_in2 = 8'hFF;
        repeat (1100) step();
        chk("slow_idle_at_enq", int'(busy2_tr[mark]), 0);
        lo_run = 0;
        while (mark + 1 + lo_run < tx2_tr.size() && !tx2_tr[mark + 1 + lo_run]) lo_run++;
        bz_run = 0;
        while (mark + 1 + bz_run < busy2_tr.size() && busy2_tr[mark + 1 + bz_run]) bz_run++;
        hi_cnt = 0;
        for (int i = mark + 1 + C2; i < mark + 1 + 10*C2; i++) if (tx2_tr[i]) hi_cnt++;
        chk("slow_start_len", lo_run, C2);
        chk("slow_frame_len", bz_run, 10*C2);
        chk("slow_high_bits", hi_cnt, 9*C2);
        chk("slow_line_idle", int'(tx2_tr[mark + 1 + 10*C2]), 1);
        chk("slow_ovf", int'(overflow2), 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/byte_change_uart_tx.md
Name: byte_change_uart_tx

Overview:
- Downstream consumer of the 8-bit parallel output of the pin passthrough test stage on the ECP5 board.
- Watches the byte, queues every value change in a small FIFO, and transmits each queued byte on a single UART line (8N1, LSB first).
- Lets a host terminal observe the pass-through data without a logic analyser.

Parameters:
- CLKS_PER_BIT, 104, clk cycles per UART bit (≥2; 104 ≈ 115200 baud at 12 MHz).
- FIFO_DEPTH, 4, change-queue entries (power of 2, ≥2).

Ports:
- clk  input  1  system clock, all logic on rising edge.
- rst_n  input  1  asynchronous active-low reset.
- data_in  input  8  monitored byte, synchronous to clk.
- tx  output  1  UART serial line, idle high.
- busy  output  1  high while a frame is on the line (START/DATA/STOP).
- fifo_level  output  log2(FIFO_DEPTH)+1  entries currently queued.
- overflow  output  1  sticky: a change was dropped because the FIFO was full.

Behaviour:
- One clock. Reset is asynchronous and active-low; every register clears immediately on rst_n low.
- Reset values: tx=1, busy=0, fifo_level=0, overflow=0, FSM=IDLE, prev=0x00, primed=0.
- Change detect:
  - First rising edge after reset release: prev<=data_in, primed<=1, no enqueue.
  - Every later edge: if data_in!=prev, then prev<=data_in and data_in is enqueued.
  - Latency: data_in changes before edge k; the entry is visible in fifo_level after edge k.
  - A value that changes and returns within one cycle is not detected. This is acceptable.
- FIFO:
  - Circular buffer with read/write pointers and one extra bit for full detection.
  - Enqueue when full: the value is dropped, overflow<=1, prev still updates. overflow clears only on reset.
  - Enqueue and dequeue on the same edge: both take effect and level is unchanged. This also applies when the FIFO is full, so the enqueue is accepted and overflow is not set.
- TX FSM states: IDLE, START, DATA, STOP.
  - IDLE: tx=1, busy=0. If the FIFO is non-empty at an edge, pop the head into the shift register, go to START, clear the baud counter.
  - START: tx=0 for CLKS_PER_BIT cycles, then go to DATA with bit index 0.
  - DATA: tx=shift[0] for CLKS_PER_BIT cycles per bit, shift right, 8 bits LSB first, then go to STOP.
  - STOP: tx=1 for CLKS_PER_BIT cycles, then go to IDLE.
  - Frame length is exactly 10*CLKS_PER_BIT cycles.
  - IDLE always lasts at least 1 cycle between frames. Back-to-back frame period is 10*CLKS_PER_BIT+1 cycles.
- Baud counter counts 0..CLKS_PER_BIT-1 and wraps at each bit boundary. Its width is clog2(CLKS_PER_BIT).
- tx and busy are driven from registers, so there is no combinational path from data_in to tx.
- End-to-end latency:
  - data_in changes before edge k with the FIFO empty and FSM in IDLE.
  - Enqueue at edge k, pop at edge k+1, tx falls after edge k+1.
- Reset mid-frame: tx returns to 1 immediately (asynchronously), the frame is truncated, and the FIFO contents are discarded.
- data_in is not synchronised inside this block. The upstream stage supplies a clk-domain value.

Test Plan:
- Reset release with data_in=0xA5 held constant, 50 cycles (CLKS_PER_BIT=4) -> fifo_level stays 0, tx stays 1, no frame sent (priming).
- After priming, data_in 0xA5->0x3C for 1 cycle then held -> fifo_level=1 for one cycle, tx low 2 edges after the change. Decoded line: start 0, bits 0,0,1,1,1,1,0,0, stop 1. Each bit 4 cycles, busy high for exactly 40 cycles.
- Six distinct changes on consecutive cycles while IDLE, FIFO_DEPTH=4 -> first pops immediately and 4 queue, sixth dropped with overflow=1. Five frames sent in order, consecutive frame starts 41 cycles apart. overflow stays 1 until reset.
- FIFO full and FSM in IDLE while data_in changes on the same edge as the pop -> fifo_level stays 4, overflow stays 0, new byte later transmitted last.
- Reset asserted at cycle 17 of a frame, with 2 entries queued -> tx=1, busy=0, fifo_level=0 immediately, no glitch. After release, priming repeats and no stale byte is sent.
- CLKS_PER_BIT=104, one change 0x00->0xFF -> start bit 104 cycles low, eight 104-cycle high bits, stop bit high, total frame 1040 cycles.
